// File: rtl/regfile_dump.sv
// regfile_dump: sequential read-out engine for the 32x32 general-purpose
// register file. A start pulse walks addresses 0..REG_NUM-1 through one
// read port and streams each word as an address/data beat over valid/ready.
//
// Optional feature: define REGFILE_DUMP_CHECKSUM_EN to append one extra beat
// (out_addr=0, out_data=XOR of all dumped words, out_last=1) after the last
// register beat. Without the macro the dump is exactly REG_NUM beats and
// out_last marks the final register beat.
module regfile_dump #(
  parameter int REG_NUM = 32,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              re,
  output logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_NUM - 1);

`ifdef REGFILE_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_HOLD = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_HOLD = 3'd2,
    S_DONE = 3'd4
  } state_t;
`endif

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0]   csum_q, csum_d;
`endif

  // Next-state and registered-output computation for the dump walk.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          idx_d   = '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_READ: begin
        // The read port answers combinationally, so the word is captured
        // in the same cycle the address is presented.
        out_data_d  = rdata;
        out_addr_d  = idx_q;
        out_valid_d = 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        out_last_d  = 1'b0;
        csum_d      = csum_q ^ rdata;
`else
        out_last_d  = (idx_q == LAST_IDX);
`endif
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        // Beat stays frozen until accepted; the file is never re-read.
        if (out_ready) begin
          if (idx_q != LAST_IDX) begin
            idx_d       = idx_q + ADDR_W'(1);
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = S_READ;
          end else begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
            out_valid_d = 1'b1;
            out_addr_d  = '0;
            out_data_d  = csum_q;
            out_last_d  = 1'b1;
            state_d     = S_CSUM;
`else
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = S_DONE;
`endif
          end
        end
      end
`ifdef REGFILE_DUMP_CHECKSUM_EN
      S_CSUM: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = S_DONE;
        end
      end
`endif
      S_DONE: begin
        // Start is not looked at here, so a request landing in DONE is dropped.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and beat registers; reset aborts any dump in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  // Read-port drive and status flags decoded from the current state.
  always_comb begin
    re    = 1'b0;
    raddr = '0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      S_READ: begin
        re    = 1'b1;
        raddr = idx_q;
        busy  = 1'b1;
      end
      S_HOLD: busy = 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      S_CSUM: busy = 1'b1;
`endif
      S_DONE: done = 1'b1;
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: register-file model with same-cycle write
// forwarding, a scoreboard of expected beats, and a table of dump scenarios.
module tb_regfile_dump;

  localparam int REG_NUM = 32;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam int LAT_BASE  = 65;
  localparam int EXP_BEATS = 33;
`else
  localparam int LAT_BASE  = 64;
  localparam int EXP_BEATS = 32;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic              re;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  regfile_dump #(.REG_NUM(REG_NUM), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .re(re), .raddr(raddr), .rdata(rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file model: r0 reads 0, a write to r7 during fwd_en is forwarded.
  logic [DATA_W-1:0] regs [REG_NUM];
  logic              fwd_en;
  logic              fwd_we;
  assign fwd_we = fwd_en && re && (raddr == 5'd7);
  assign rdata  = !re ? '0 :
                  (raddr == '0) ? '0 :
                  fwd_we ? 32'hDEADBEEF : regs[raddr];

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  typedef struct {
    int rmode;    // 0 ready high, 1 3-low/1-high, 2 random
    int fill;     // 0 0x1000+n, 1 n*0x01010101, 2 random
    bit fwd;
    int x1, x2, x3;   // extra start pulses (edge offsets), 0 = none
    int exp_beats;
    int exp_re;
    int exp_lat;
  } vec_t;

  beat_t q[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  int    ready_mode = 0;
  int    rphase = 0;
  int    stalls, re_cnt, done_cnt = 0, done_cyc, beat_cnt;
  logic  hold_vld = 1'b0;
  beat_t hold_b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fill_regs(input int mode);
    for (int n = 0; n < REG_NUM; n++) begin
      case (mode)
        0:       regs[n] = 32'h1000 + DATA_W'(n);
        1:       regs[n] = DATA_W'(n) * 32'h01010101;
        default: regs[n] = $urandom;
      endcase
    end
  endtask

  task automatic push_expected(input bit fwd);
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] xr;
    beat_t b;
    xr = '0;
    for (int n = 0; n < REG_NUM; n++) begin
      d = (n == 0) ? '0 : (fwd && n == 7) ? 32'hDEADBEEF : regs[n];
      xr = xr ^ d;
      b.addr = ADDR_W'(n);
      b.data = d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      b.last = 1'b0;
`else
      b.last = (n == REG_NUM - 1);
`endif
      q.push_back(b);
    end
`ifdef REGFILE_DUMP_CHECKSUM_EN
    b.addr = '0;
    b.data = xr;
    b.last = 1'b1;
    q.push_back(b);
`endif
  endtask

  task automatic run_dump(input vec_t v);
    int k, t, done_before;
    fill_regs(v.fill);
    fwd_en = v.fwd;
    ready_mode = v.rmode;
    q.delete();
    push_expected(v.fwd);
    stalls = 0; re_cnt = 0; beat_cnt = 0;
    done_before = done_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = cyc;
    t = 0;
    while (done_cnt == done_before && t < 600) begin
      @(posedge clk); #1;
      t++;
      start = (t + 1 == v.x1) || (t + 1 == v.x2) || (t + 1 == v.x3);
    end
    start = 1'b0;
    if (done_cnt == done_before) chk("done_timeout", 64'(t), 64'(0));
    repeat (4) @(posedge clk);
    #1;
    chk("done_cycle", 64'(done_cyc - k), 64'(v.exp_lat + stalls));
    chk("done_count", 64'(done_cnt - done_before), 64'(1));
    chk("re_count", 64'(re_cnt), 64'(v.exp_re));
    chk("beat_count", 64'(beat_cnt), 64'(v.exp_beats));
    chk("beats_left", 64'(q.size()), 64'(0));
    chk("busy_after_done", 64'(busy), 64'(0));
    if (v.x1 != 0) begin
      repeat (70) @(posedge clk);
      #1;
      chk("no_restart_re", 64'(re_cnt), 64'(v.exp_re));
      chk("no_restart_done", 64'(done_cnt - done_before), 64'(1));
    end
    fwd_en = 1'b0;
    ready_mode = 0;
  endtask

  vec_t tbl[6];

  initial begin
    int k, done_before;
    rst = 1'b1; start = 1'b0; out_ready = 1'b1; fwd_en = 1'b0;
    fill_regs(0);

    tbl[0] = '{0, 0, 1'b0, 0, 0, 0, EXP_BEATS, 32, LAT_BASE};
    tbl[1] = '{1, 0, 1'b0, 0, 0, 0, EXP_BEATS, 32, LAT_BASE};
    tbl[2] = '{0, 0, 1'b1, 0, 0, 0, EXP_BEATS, 32, LAT_BASE};
    tbl[3] = '{0, 0, 1'b0, 5, 30, LAT_BASE + 1, EXP_BEATS, 32, LAT_BASE};
    tbl[4] = '{2, 2, 1'b0, 0, 0, 0, EXP_BEATS, 32, LAT_BASE};
    tbl[5] = '{0, 1, 1'b0, 0, 0, 0, EXP_BEATS, 32, LAT_BASE};

    fork
      // Output monitor: judges the beat that the next rising edge will see.
      forever begin
        @(negedge clk);
        if (rst) begin
          hold_vld = 1'b0;
        end else begin
          if (re) re_cnt++;
          if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("done_quiet", 64'({out_valid, out_last, busy}), 64'(0));
          end
          if (out_valid) begin
            if (hold_vld)
              chk("hold_stable", 64'({out_addr, out_data, out_last}), 64'(hold_b));
            if (!out_ready) begin
              stalls++;
              hold_vld = 1'b1;
              hold_b = '{out_addr, out_data, out_last};
            end else begin
              hold_vld = 1'b0;
              beat_cnt++;
              if (q.size() == 0) begin
                chk("unexpected_beat", 64'({out_addr, out_data}), 64'(0));
              end else begin
                beat_t e;
                e = q.pop_front();
                chk("beat_addr", 64'(out_addr), 64'(e.addr));
                chk("beat_data", 64'(out_data), 64'(e.data));
                chk("beat_last", 64'(out_last), 64'(e.last));
              end
            end
          end else begin
            hold_vld = 1'b0;
          end
        end
      end
      // Downstream ready pattern.
      forever begin
        @(posedge clk); #1;
        rphase++;
        case (ready_mode)
          0:       out_ready = 1'b1;
          1:       out_ready = (rphase % 4 == 3);
          default: out_ready = ($urandom_range(0, 1) == 1);
        endcase
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 64'({re, raddr, out_valid, out_addr, out_data, out_last, busy, done}), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) run_dump(tbl[i]);

    // Reset mid-dump: abort ten edges after start, then redo the dump.
    fill_regs(1);
    q.delete();
    push_expected(1'b0);
    done_before = done_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = cyc;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_state", 64'({re, raddr, out_valid, out_addr, out_data, out_last, busy, done}), 64'(0));
    chk("abort_edge", 64'(cyc - k), 64'(10));
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    repeat (80) @(posedge clk);
    #1;
    chk("no_done_after_abort", 64'(done_cnt - done_before), 64'(0));
    chk("idle_after_abort", 64'({busy, out_valid}), 64'(0));
    run_dump(tbl[5]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Sequential read-out engine that is the read-side initiator for the 32×32 general-purpose register file. On a start pulse it walks register addresses 0..31 through one register-file read port, registers each returned word, and streams it out as address/data beats over a valid/ready interface. It feeds the debug/trace path and lets a bench or debug host snapshot architectural state without touching the decode stage's read ports.

## Interface
Parameters:
- REG_NUM, 32, number of registers walked; addresses 0..REG_NUM-1
- ADDR_W, 5, register address width, equal to `RegAddrBus`
- DATA_W, 32, register data width, equal to `RegBus`

Ports:
- clk  in  1  sole clock; all state changes on rising edge
- rst  in  1  reset; synchronous and active-high
- start  in  1  request a dump; sampled only in IDLE
- busy  out  1  high in READ, HOLD and CSUM
- done  out  1  one-cycle pulse after the final beat is accepted
- re  out  1  register-file read enable
- raddr  out  ADDR_W  register-file read address
- rdata  in  DATA_W  register-file read data; combinational from re/raddr
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the beat
- out_addr  out  ADDR_W  register index of the current beat
- out_data  out  DATA_W  register contents of the current beat
- out_last  out  1  marks the final beat of the dump

## Operation
- Reset value, while rst=1 at an edge: state IDLE; idx=0; all outputs 0, including re, raddr, out_valid, out_addr, out_data, out_last, busy and done.
- An accepted beat is a rising edge with out_valid=1 and out_ready=1.
- FSM states: IDLE, READ, HOLD, CSUM, DONE.
- **IDLE**
  - start=1 goes to READ with idx=0.
  - start=0 stays in IDLE.
- **READ**
  - Drive re=1 and raddr=idx combinationally. In all other states re=0 and raddr=0.
  - At the edge, capture out_data<=rdata and out_addr<=idx, set out_valid<=1, and go to HOLD.
  - out_last<=1 when idx=REG_NUM-1 and checksum is compiled out.
- **HOLD**
  - out_* stay stable until accepted.
  - On accept with idx<REG_NUM-1: idx<=idx+1, out_valid<=0, out_last<=0, go to READ.
  - On accept with idx=REG_NUM-1: go to DONE, or to CSUM when checksum is compiled in.
- **CSUM** (checksum build only; see Configuration)
  - On entry: out_valid<=1, out_addr<=0, out_data<=checksum, out_last<=1.
  - Hold until accepted, then go to DONE.
- **DONE**
  - done=1 for exactly one cycle, with out_valid=0 and out_last=0.
  - Next state is IDLE.
- Data captured in READ is whatever the register file returns that cycle. This includes its same-cycle write forwarding: a concurrent write to idx appears in the dump. Address 0 always returns 0.
- start is ignored outside IDLE, and a start arriving during DONE is dropped. idx is never incremented past REG_NUM-1, so no wrap occurs.
- rst=1 mid-dump aborts at that edge: return to IDLE with reset values. No done pulse and no partial checksum beat.

## Timing
- start sampled at edge k: re=1 during cycle k→k+1, and first out_valid is seen after edge k+1.
- With out_ready held high, beat i is accepted at edge k+2+2i, so throughput is one beat per 2 cycles.
- Checksum compiled out: last beat accepted at edge k+64, done high in cycle k+64→k+65.
- Checksum compiled in: checksum beat accepted at edge k+65, done high in cycle k+65→k+66.
- Each cycle of out_ready=0 while in HOLD or CSUM adds exactly one cycle. Back-pressure never causes the register file to be re-read.
- busy falls at the edge entering DONE, and is low during the done cycle.

## Configuration
- Macro: REGFILE_DUMP_CHECKSUM_EN.
- Defined:
  - Keep a DATA_W running XOR, cleared on start and XORed with rdata in each READ capture.
  - After register REG_NUM-1 is accepted, emit one extra beat from CSUM: out_addr=0, out_data=XOR of all REG_NUM words, out_last=1.
  - out_last is 0 on all register beats.
- Undefined: no XOR register and no CSUM state. out_last=1 on the register REG_NUM-1 beat. The dump is exactly REG_NUM beats.

## Test plan
- Reset mid-dump, with reg[n]=n×0x01010101, start at edge 10 and rst=1 at edge 20: outputs all 0 after edge 20, no done pulse, and a new start then yields a full, correct dump.
- Full dump, reg[n]=0x1000+n, out_ready=1, start pulse: 32 beats (addr n, data 0x1000+n; addr 0 data 0), done exactly at cycle k+64, out_last on beat 31.
- Back-pressure: out_ready toggled with a 3-low/1-high pattern. Beats are identical to the previous case, each beat is held stable until accepted, and re is asserted exactly 32 times.
- Forwarding: a write of 0xDEADBEEF to r7 in the same cycle READ addresses r7. Beat 7 data must be 0xDEADBEEF.
- Start while busy: start pulses at k+5 and k+30 are ignored, exactly one done pulse occurs, and busy is low after done.
- REGFILE_DUMP_CHECKSUM_EN defined, reg[n]=0x1000+n: 33 beats, the last with addr 0, data 0x00001000 (XOR of 0x1000..0x101F; reg 0 reads 0) and out_last=1. Done occurs at cycle k+65.
